// File: rtl/intr_vec_arbiter.sv
// Fixed-priority interrupt arbiter and vectoring controller for the MicroBlaze fast-interrupt port.
// Latches source edges, grants one source at a time and sequences the two-bit acknowledge handshake.
module intr_vec_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               sys_clk,
  input  logic               ext_rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [1:0]         intr_ack,
  output logic               interrupt,
  output logic [31:0]        interrupt_address,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2,
    S_WAIT_IE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACK_NONE   = 2'b00,
    ACK_TAKEN  = 2'b01,
    ACK_RETURN = 2'b10,
    ACK_IE     = 2'b11
  } ack_t;

  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_rise;
  logic [NUM_SRC-1:0] r_pending;

  state_t             r_state;
  logic               r_interrupt;
  logic [31:0]        r_addr;
  logic [ID_W-1:0]    r_id;
  logic               r_busy;

  state_t             w_state_nxt;
  logic               w_interrupt_nxt;
  logic [31:0]        w_addr_nxt;
  logic [ID_W-1:0]    w_id_nxt;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_sync_out;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_valid;

  assign w_sync_out    = r_sync[SYNC_STAGES-1];
  assign w_eligible    = r_pending & src_mask;
  assign w_grant_valid = |w_eligible;

  // Input path: synchronizer chain, previous-value flop and a registered rise pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the synchronizer flops are reset too; a source held high through reset then yields one edge.
  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev    <= '0;
      r_rise    <= '0;
      r_pending <= '0;
    end else begin
      r_sync[0] <= src_irq;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev    <= w_sync_out;
      r_rise    <= w_sync_out & ~r_prev;
      // A new event in the acceptance cycle wins over the clear.
      r_pending <= (r_pending & ~w_clr) | r_rise;
    end
  end

  // Lowest enabled index wins.
  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_grant_idx = ID_W'(i);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_interrupt_nxt = r_interrupt;
    w_addr_nxt      = r_addr;
    w_id_nxt        = r_id;
    w_clr           = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt     = S_REQ;
          w_interrupt_nxt = 1'b1;
          w_id_nxt        = w_grant_idx;
          w_addr_nxt      = BASE_ADDR + (32'(w_grant_idx) * VEC_STRIDE);
        end
      end
      S_REQ: begin
        if (intr_ack == ACK_TAKEN) begin
          w_state_nxt     = S_SERVICE;
          w_interrupt_nxt = 1'b0;
          w_clr[r_id]     = 1'b1;
        end
      end
      S_SERVICE: begin
        if (intr_ack == ACK_RETURN) w_state_nxt = S_WAIT_IE;
      end
      S_WAIT_IE: begin
        if (intr_ack == ACK_IE) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      r_state     <= S_IDLE;
      r_interrupt <= 1'b0;
      r_addr      <= '0;
      r_id        <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= w_interrupt_nxt;
      r_addr      <= w_addr_nxt;
      r_id        <= w_id_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign interrupt         = r_interrupt;
  assign interrupt_address = r_addr;
  assign active_id         = r_id;
  assign pending           = r_pending;
  assign busy              = r_busy;

endmodule

// File: doc/intr_vec_arbiter.md
# intr_vec_arbiter

Fixed-priority interrupt arbiter and vectoring controller in front of the MicroBlaze fast-interrupt port. It latches rising edges from up to NUM_SRC asynchronous interrupt sources and presents one request at a time to the processor, together with its vector address. It then sequences the processor's two-bit acknowledge handshake through to interrupt re-enable. It replaces the tie-off of the processor's interrupt address input and drives the processor interrupt line in the processor-system top.

## Interface
- NUM_SRC, 4, number of interrupt sources (1..16); index 0 is highest priority
- BASE_ADDR, 32'h0000_0100, vector address of source 0
- VEC_STRIDE, 32'h0000_0010, address increment per source index
- SYNC_STAGES, 2, synchronizer depth for src_irq (>=2)

Ports:
- sys_clk  input  1  single system clock; all logic is on the rising edge
- ext_rst  input  1  synchronous, active-high reset
- src_irq  input  NUM_SRC  asynchronous interrupt sources; a rising edge marks an event
- src_mask  input  NUM_SRC  synchronous; 1 = source enabled for arbitration
- intr_ack  input  2  processor Interrupt_Ack: 00 none, 01 taken, 10 return executed, 11 IE re-enabled
- interrupt  output  1  to the processor interrupt input; level; registered
- interrupt_address  output  32  vector of the granted source; registered
- active_id  output  $clog2(NUM_SRC) (min 1)  index of the granted or in-service source
- pending  output  NUM_SRC  latched-but-unserviced events
- busy  output  1  high in every state except IDLE

## Operation
- Input path: each src_irq bit passes through SYNC_STAGES flops. A registered previous-value flop follows. A rise is detected when the synced value is 1 and the previous value is 0.
- The synchronizer and previous-value flops reset to 0. A source held high through reset therefore produces exactly one edge after reset is released.
- pending[i] is set on a detected rise of source i, regardless of src_mask. It is cleared only on acceptance, defined below.
- If a set and a clear of the same bit occur in the same cycle, the set wins: the bit stays 1 and the source is serviced again.
- Masked pending bits are held. They become eligible when the mask bit goes high.
- FSM states: IDLE, REQ, SERVICE, WAIT_IE.
  - IDLE: if (pending & src_mask) != 0, grant the lowest set index g. On that transition, register active_id = g and interrupt_address = BASE_ADDR + g*VEC_STRIDE (32-bit, wrap mod 2^32), set interrupt = 1, and go to REQ.
  - REQ: interrupt is held at 1 and the address is frozen. The grant is not re-arbitrated, even if a higher-priority source pends or the granted source's mask drops. On intr_ack == 01: interrupt = 0, clear pending[g] (acceptance), go to SERVICE.
  - SERVICE: on intr_ack == 10, go to WAIT_IE.
  - WAIT_IE: on intr_ack == 11, go to IDLE. active_id and interrupt_address keep their last values.
- An intr_ack code not expected in the current state is ignored, and the state is unchanged.
- Reset (ext_rst = 1 on a clock edge), including mid-handshake, produces the following on the next cycle: state IDLE, interrupt 0, interrupt_address 0, active_id 0, pending 0, busy 0, and all synchronizer flops 0.

## Timing
- A src_irq rise sampled at edge k sets pending at edge k+SYNC_STAGES+1. This is k+3 cycles at the default depth.
- From pending visible in IDLE to interrupt = 1: 1 cycle.
- From intr_ack == 01 sampled to interrupt = 0 and pending[g] clear: 1 cycle.
- intr_ack == 11 sampled in WAIT_IE gives IDLE on the next cycle. Arbitration in that IDLE cycle means back-to-back service reasserts interrupt 2 cycles after the 11 code.
- busy is 1 in REQ, SERVICE and WAIT_IE; it is registered alongside the state.

## Test plan
- Single source: reset, then pulse src_irq[2] with mask = 4'hF. Required: pending = 4'b0100 three cycles later; the next cycle shows interrupt = 1, interrupt_address = 32'h0000_0120, active_id = 2. Drive ack 01, then 10, then 11: interrupt drops one cycle after 01, pending returns to 0, busy returns to 0 one cycle after 11.
- Priority: raise src_irq[3] and src_irq[1] on the same cycle. Required: source 1 (address 32'h110) is served first; after its 11 ack, source 3 (address 32'h130) is requested 2 cycles later.
- No preemption: while in REQ for source 2, pulse src_irq[0]. Required: interrupt_address stays 32'h120 until ack 01; source 0 is served next.
- Mask: pulse src_irq[1] with src_mask[1] = 0. Required: pending[1] = 1 and interrupt stays 0. Set the mask bit high: interrupt = 1 on the next cycle with address 32'h110.
- Re-arm and bad ack: a second edge on source 2 lands in the same cycle as its 01 ack, so pending[2] stays 1 and source 2 is serviced twice. Separately, ack 10 while in REQ must be ignored, with state held.
- Reset mid-operation: assert ext_rst while in SERVICE. Required: interrupt, pending, busy and interrupt_address are all 0 on the next cycle. A source held high through reset is serviced exactly once afterward.
